// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, branch/flush redirect, IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt/bubble_cnt performance counters.
module inst_fetch #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           INST_W   = 64,
  parameter int unsigned           PC_STEP  = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   pc_nxt_s;
  logic                rom_ce_r;
  logic [ADDR_W-1:0]   id_pc_r;
  logic [INST_W-1:0]   id_inst_r;
  logic                id_valid_r;
  logic                pend_valid_r;
  logic [ADDR_W-1:0]   pend_target_r;
  logic                capture_s;
  logic                squash_s;
  logic                set_pend_s;
  logic                clear_pend_s;

  // Next-state, next-PC and IF/ID control; flush > stall > branch > sequential.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    capture_s    = 1'b0;
    squash_s     = 1'b0;
    set_pend_s   = 1'b0;
    clear_pend_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
        pc_nxt_s    = RESET_PC;
      end
      ST_RUN: begin
        if (flush) begin
          pc_nxt_s     = flush_target;
          squash_s     = 1'b1;
          clear_pend_s = 1'b1;
        end else if (stall) begin
          // A branch arriving while stalled is parked until the stall lifts.
          if (branch_flag) begin
            set_pend_s = 1'b1;
          end else begin
            set_pend_s = 1'b0;
          end
        end else if (branch_flag) begin
          pc_nxt_s     = branch_target;
          squash_s     = 1'b1;
          clear_pend_s = 1'b1;
        end else if (pend_valid_r) begin
          pc_nxt_s     = pend_target_r;
          squash_s     = 1'b1;
          clear_pend_s = 1'b1;
        end else begin
          pc_nxt_s  = pc_r + ADDR_W'(PC_STEP);
          capture_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
        pc_nxt_s    = RESET_PC;
      end
    endcase
  end

  // Controller state, PC and ROM enable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_BOOT;
      pc_r     <= RESET_PC;
      rom_ce_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      rom_ce_r <= (state_nxt_s == ST_RUN);
    end
  end

  // IF/ID pipeline register; squashed slots are forced to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_r    <= '0;
      id_inst_r  <= '0;
      id_valid_r <= 1'b0;
    end else if (capture_s) begin
      id_pc_r    <= pc_r;
      id_inst_r  <= rom_inst;
      id_valid_r <= 1'b1;
    end else if (squash_s) begin
      id_pc_r    <= '0;
      id_inst_r  <= '0;
      id_valid_r <= 1'b0;
    end
  end

  // One-entry pending branch; a newer stalled branch overwrites the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_r  <= 1'b0;
      pend_target_r <= '0;
    end else if (clear_pend_s) begin
      pend_valid_r  <= 1'b0;
      pend_target_r <= '0;
    end else if (set_pend_s) begin
      pend_valid_r  <= 1'b1;
      pend_target_r <= branch_target;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] bubble_cnt_r;

  // Count valid IF/ID captures and squashed/flushed slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
    end else begin
      if (capture_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
      if (squash_s) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
`endif

  assign rom_ce   = rom_ce_r;
  assign rom_addr = pc_r;
  assign id_pc    = id_pc_r;
  assign id_inst  = id_inst_r;
  assign id_valid = id_valid_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; ROM data is {addr, ~addr}.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [63:0] rom_inst;
  logic [31:0] id_pc;
  logic [63:0] id_inst;
  logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_target  (flush_target),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .bubble_cnt    (bubble_cnt)
`endif
  );

  assign rom_inst = {rom_addr, ~rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; flush = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL rst_ce got %b want 0", rom_ce); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", rom_addr); end
    checks++; if ({id_valid, id_pc, id_inst} !== 97'd0) begin errors++; $display("FAIL rst_id got %b %h %h want zeros", id_valid, id_pc, id_inst); end
    step();
    rst = 1'b0;
    #2;
    checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL boot_ce got %b want 0", rom_ce); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    step();
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL run0 got ce=%b addr=%h v=%b want 1 0 0", rom_ce, rom_addr, id_valid); end
    for (int i = 1; i < 4; i++) begin
      step();
      exp_addr = 32'h10 * i;
      checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL seq_addr%0d got %h want %h", i, rom_addr, exp_addr); end
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_addr - 32'h10 || id_inst !== {exp_addr - 32'h10, ~(exp_addr - 32'h10)}) begin errors++; $display("FAIL seq_id%0d got v=%b pc=%h inst=%h want pc=%h", i, id_valid, id_pc, id_inst, exp_addr - 32'h10); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    step();
    step();
    checks++; if (rom_addr !== 32'h20) begin errors++; $display("FAIL br_pre got %h want 20", rom_addr); end
    branch_flag = 1'b1; branch_target = 32'h100;
    step();
    branch_flag = 1'b0;
    checks++; if (rom_addr !== 32'h100) begin errors++; $display("FAIL br_addr got %h want 100", rom_addr); end
    checks++; if ({id_valid, id_pc, id_inst} !== 97'd0) begin errors++; $display("FAIL br_squash got %b %h %h want zeros", id_valid, id_pc, id_inst); end
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || rom_addr !== 32'h110) begin errors++; $display("FAIL br_after got v=%b pc=%h addr=%h want 1 100 110", id_valid, id_pc, rom_addr); end
  endtask

  task automatic test_stall_branch();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_flag = (i == 1); branch_target = 32'h200;
      step();
      branch_flag = 1'b0;
      checks++; if (rom_addr !== 32'h110 || id_pc !== 32'h100 || id_valid !== 1'b1 || id_inst !== {32'h100, ~32'h100}) begin errors++; $display("FAIL stall_hold%0d got addr=%h pc=%h v=%b want 110 100 1", i, rom_addr, id_pc, id_valid); end
    end
    stall = 1'b0;
    step();
    checks++; if (rom_addr !== 32'h200 || id_valid !== 1'b0 || id_inst !== 64'd0) begin errors++; $display("FAIL pend_apply got addr=%h v=%b want 200 0", rom_addr, id_valid); end
    step();
    checks++; if (rom_addr !== 32'h210 || id_pc !== 32'h200 || id_valid !== 1'b1) begin errors++; $display("FAIL pend_after got addr=%h pc=%h want 210 200", rom_addr, id_pc); end
    // Overwrite of pending target by a later stalled branch.
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
    step();
    branch_target = 32'h400;
    step();
    stall = 1'b0; branch_flag = 1'b0;
    step();
    checks++; if (rom_addr !== 32'h400) begin errors++; $display("FAIL pend_overwrite got %h want 400", rom_addr); end
    // New branch in the unstalled cycle beats the pending one.
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h600;
    step();
    stall = 1'b0; branch_target = 32'h700;
    step();
    branch_flag = 1'b0;
    checks++; if (rom_addr !== 32'h700 || id_valid !== 1'b0) begin errors++; $display("FAIL new_wins got addr=%h v=%b want 700 0", rom_addr, id_valid); end
    step();
    checks++; if (rom_addr !== 32'h710 || id_pc !== 32'h700) begin errors++; $display("FAIL new_wins_after got addr=%h pc=%h want 710 700", rom_addr, id_pc); end
  endtask

  task automatic test_flush();
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h80;
    step();
    flush = 1'b1; flush_target = 32'h40;
    step();
    flush = 1'b0; stall = 1'b0; branch_flag = 1'b0;
    checks++; if (rom_addr !== 32'h40 || {id_valid, id_pc, id_inst} !== 97'd0) begin errors++; $display("FAIL flush got addr=%h v=%b pc=%h want 40 0 0", rom_addr, id_valid, id_pc); end
    step();
    checks++; if (rom_addr !== 32'h50 || id_pc !== 32'h40 || id_valid !== 1'b1) begin errors++; $display("FAIL flush_after got addr=%h pc=%h want 50 40", rom_addr, id_pc); end
  endtask

  task automatic test_wrap();
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFF0;
    step();
    branch_flag = 1'b0;
    step();
    checks++; if (rom_addr !== 32'h0 || id_pc !== 32'hFFFF_FFF0 || id_inst !== {32'hFFFF_FFF0, 32'h0000_000F}) begin errors++; $display("FAIL wrap got addr=%h pc=%h inst=%h want 0 fffffff0", rom_addr, id_pc, id_inst); end
  endtask

  task automatic test_async_reset();
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
    step();
    branch_flag = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || {id_valid, id_pc, id_inst} !== 97'd0) begin errors++; $display("FAIL async_rst got ce=%b addr=%h v=%b pc=%h want all zero", rom_ce, rom_addr, id_valid, id_pc); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin errors++; $display("FAIL cnt_rst got %0d %0d want 0 0", fetch_cnt, bubble_cnt); end
`endif
    step();
    rst = 1'b0; stall = 1'b0;
    step();
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin errors++; $display("FAIL restart got ce=%b addr=%h want 1 0", rom_ce, rom_addr); end
    step();
    checks++; if (rom_addr !== 32'h10 || id_pc !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL restart_after got addr=%h pc=%h v=%b want 10 0 1", rom_addr, id_pc, id_valid); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; flush = 1'b0;
    branch_target = 32'h0; flush_target = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_branch();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, width of program-counter and ROM address.
REQ-002 Parameter INST_W, default 64, width of instruction word.
REQ-003 Parameter PC_STEP, default 16, PC increment per sequential fetch.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 stall  in  1  hold request from downstream pipeline.
REQ-008 branch_flag  in  1  redirect request, valid for one cycle.
REQ-009 branch_target  in  ADDR_W  redirect address, sampled when branch_flag=1.
REQ-010 flush  in  1  exception flush, valid for one cycle.
REQ-011 flush_target  in  ADDR_W  handler address, sampled when flush=1.
REQ-012 rom_ce  out  1  instruction ROM chip enable.
REQ-013 rom_addr  out  ADDR_W  current PC driven to ROM.
REQ-014 rom_inst  in  INST_W  combinational ROM read data for rom_addr.
REQ-015 id_pc  out  ADDR_W  PC of instruction presented to decode.
REQ-016 id_inst  out  INST_W  instruction presented to decode.
REQ-017 id_valid  out  1  id_pc/id_inst hold a real instruction.

Function
REQ-018 Two-state controller: BOOT, RUN; BOOT entered on reset, RUN entered on first clock edge after rst deasserts.
REQ-019 In BOOT, rom_ce SHALL be 0, rom_addr SHALL equal RESET_PC, id_valid SHALL be 0.
REQ-020 In RUN, rom_ce SHALL be 1.
REQ-021 IF/ID register SHALL capture rom_addr and rom_inst each non-stalled RUN cycle; fetch-to-decode latency exactly one cycle.
REQ-022 Without stall/branch/flush, PC SHALL advance by PC_STEP each cycle, wrapping modulo 2^ADDR_W.
REQ-023 Priority: flush > stall > branch > sequential.
REQ-024 flush=1: PC SHALL load flush_target next cycle, id_valid SHALL be 0 next cycle, any pending branch SHALL be discarded, regardless of stall.
REQ-025 branch_flag=1 with stall=0: PC SHALL load branch_target next cycle; instruction fetched in the branch cycle SHALL be squashed (id_valid=0, id_inst=0); no delay slot.
REQ-026 stall=1: PC, id_pc, id_inst, id_valid SHALL hold their values.
REQ-027 branch_flag=1 while stall=1: target SHALL be latched in a one-entry pending register; applied as in REQ-025 on first cycle stall=0; a later branch while pending SHALL overwrite the pending target.
REQ-028 Pending branch and new branch_flag in the same unstalled cycle: new branch_target SHALL win.
REQ-029 When id_valid=0, id_inst SHALL be all zeros and id_pc SHALL be zero.

Reset
REQ-030 rst=1 SHALL immediately force: state=BOOT, PC=RESET_PC, rom_ce=0, id_pc=0, id_inst=0, id_valid=0, pending branch cleared, any counters cleared.
REQ-031 Reset asserted mid-stall or with a pending branch SHALL discard all held state; fetch restarts at RESET_PC.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: output fetch_cnt (32 bits) SHALL count cycles where a valid instruction enters IF/ID, and output bubble_cnt (32 bits) SHALL count squashed or flushed slots; both wrap at 2^32, clear on reset.
REQ-033 Macro FETCH_PERF_CNT_EN undefined: fetch_cnt and bubble_cnt ports and logic SHALL not exist; all other behaviour identical.

Verification
REQ-034 Release rst, no stalls, 4 cycles -> rom_ce=0 first cycle, then rom_addr 0x00,0x10,0x20,0x30; id_pc follows one cycle later with id_valid=1.
REQ-035 Branch_flag=1, branch_target=0x100 while PC=0x20 -> next rom_addr=0x100; id_valid=0 for slot of 0x20; following id_pc=0x100.
REQ-036 Stall=1 for 3 cycles with branch_flag pulse (target 0x200) in second stall cycle -> PC and IF/ID frozen; first unstalled cycle then rom_addr=0x200 next.
REQ-037 Flush=1 (target 0x40) simultaneous with stall=1 and branch_flag=1 (target 0x80) -> next rom_addr=0x40, id_valid=0, 0x80 never fetched.
REQ-038 PC=2^32-16, no events -> next rom_addr=0x0.
REQ-039 Assert rst asynchronously mid-stall with pending branch -> outputs zero and rom_ce=0 before next edge; after release fetch starts at RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.
